// File: rtl/hazard_pkg.sv
// Shared types for the multi-cycle hazard unit:
// MDU FSM state, forwarding select codes, counter sizing.
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Width of the MDU down-counter: ceil(log2(lat)), never below 1.
  function automatic int mdu_cnt_w(input int lat);
    int w;
    w = $clog2(lat);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mdu_stall_ctrl.sv
// Holds the pipeline in E while a MUL/DIV op runs;
// stall is asserted for MDU_LAT-1 cycles per op.
module mdu_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic freeze,
  output logic stall,
  output logic busy
);

  localparam int CW = mdu_cnt_w(MDU_LAT);
  localparam int LOAD = (MDU_LAT > 1) ? MDU_LAT - 2 : 0;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD);
  localparam bit MULTI = (MDU_LAT > 1);

  mdu_state_e    state_q;
  mdu_state_e    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          go;

  assign go = start && MULTI;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A stalled memory stage freezes the op in place.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    busy  = (state_q == BUSY);
    unique case (state_q)
      IDLE: stall = go && !freeze;
      BUSY: stall = (cnt_q != '0);
    endcase
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for a 5-stage core with a multi-cycle MDU:
// forwarding, load-use and MDU stalls, flushes, stall counter.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              result_src_e0,
  input  logic              pc_src_e,
  input  logic              mdu_start_e,
  input  logic              dmem_wait,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             lw_stall;
  logic             mdu_stall;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != '0) begin
      if (reg_write_m && rs == rd_m) begin
        sel = FWD_MEM;
      end else if (reg_write_w && rs == rd_w) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  mdu_stall_ctrl #(
    .MDU_LAT(MDU_LAT)
  ) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .start (mdu_start_e),
    .freeze(dmem_wait),
    .stall (mdu_stall),
    .busy  (mdu_busy)
  );

  always_comb begin
    forward_ae = FWD_RF;
    forward_be = FWD_RF;
    if (!rst) begin
      forward_ae = fwd_sel(rs1_e);
      forward_be = fwd_sel(rs2_e);
    end
  end

  assign lw_stall = result_src_e0
                 && (rd_e != '0)
                 && (rs1_d == rd_e || rs2_d == rd_e);

  // Priority: reset, memory wait, MDU, then load-use/branch.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (dmem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (mdu_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
    end else begin
      stall_f = lw_stall;
      stall_d = lw_stall;
      flush_d = pc_src_e;
      flush_e = lw_stall | pc_src_e;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: combinational vector table
// plus MDU, memory-wait, reset and saturation sequences.
module tb_hazard_unit_mc;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_m, reg_write_w, result_src_e0;
  logic       pc_src_e, mdu_start_e, dmem_wait;

  logic        sf, sd, se, sm, fd, fe, busy;
  logic [1:0]  fae, fbe;
  logic [15:0] cnt;

  logic        s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_busy;
  logic [1:0]  s_fae, s_fbe;
  logic [3:0]  s_cnt;

  logic        l_sf, l_sd, l_se, l_sm, l_fd, l_fe, l_busy;
  logic [1:0]  l_fae, l_fbe;
  logic [15:0] l_cnt;

  int total = 0;
  int bad   = 0;

  hazard_unit_mc u_dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e0(result_src_e0), .pc_src_e(pc_src_e),
    .mdu_start_e(mdu_start_e), .dmem_wait(dmem_wait),
    .stall_f(sf), .stall_d(sd), .stall_e(se), .stall_m(sm),
    .flush_d(fd), .flush_e(fe),
    .forward_ae(fae), .forward_be(fbe),
    .mdu_busy(busy), .stall_cnt(cnt)
  );

  hazard_unit_mc #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e0(result_src_e0), .pc_src_e(pc_src_e),
    .mdu_start_e(mdu_start_e), .dmem_wait(dmem_wait),
    .stall_f(s_sf), .stall_d(s_sd), .stall_e(s_se), .stall_m(s_sm),
    .flush_d(s_fd), .flush_e(s_fe),
    .forward_ae(s_fae), .forward_be(s_fbe),
    .mdu_busy(s_busy), .stall_cnt(s_cnt)
  );

  hazard_unit_mc #(.MDU_LAT(1)) u_l1 (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e0(result_src_e0), .pc_src_e(pc_src_e),
    .mdu_start_e(mdu_start_e), .dmem_wait(dmem_wait),
    .stall_f(l_sf), .stall_d(l_sd), .stall_e(l_se), .stall_m(l_sm),
    .flush_d(l_fd), .flush_e(l_fe),
    .forward_ae(l_fae), .forward_be(l_fbe),
    .mdu_busy(l_busy), .stall_cnt(l_cnt)
  );

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       rwm, rww, ld, pc, dw;
    logic [1:0] fae, fbe;
    logic [5:0] ctl;
  } vec_t;

  vec_t vec [13];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_m = 0; reg_write_w = 0; result_src_e0 = 0;
    pc_src_e = 0; mdu_start_e = 0; dmem_wait = 0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [5:0] ctl_now();
    return {sf, sd, se, sm, fd, fe};
  endfunction

  logic e_se [6];
  logic e_sm [6];
  logic e_bz [6];

  initial begin
    // rs1_d rs2_d rs1_e rs2_e rd_e rd_m rd_w rwm rww ld pc dw fae fbe ctl
    vec[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 6'b000000};
    vec[1]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd5,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 6'b000000};
    vec[2]  = '{5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 5'd4, 5'd3,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 6'b000000};
    vec[3]  = '{5'd0, 5'd0, 5'd5, 5'd6, 5'd0, 5'd5, 5'd5,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 6'b000000};
    vec[4]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 6'b110001};
    vec[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 6'b000000};
    vec[6]  = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 6'b110001};
    vec[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 6'b000011};
    vec[8]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0,
                1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 6'b110011};
    vec[9]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0,
                1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 6'b111100};
    vec[10] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 6'b000000};
    vec[11] = '{5'd0, 5'd0, 5'd12, 5'd12, 5'd0, 5'd12, 5'd12,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 6'b000000};
    vec[12] = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd3,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 6'b000000};

    // Reset behaviour, with forwarding inputs that would otherwise hit.
    clr();
    rst = 1'b1;
    rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1;
    tick();
    #3;
    chk("rst_ctl", ctl_now(), 6'b000011);
    chk("rst_fae", fae, 2'b00);
    rst = 1'b0;
    clr();
    tick();
    #3;
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);

    // Combinational table.
    for (int i = 0; i < 13; i++) begin
      tick();
      rs1_d = vec[i].rs1_d; rs2_d = vec[i].rs2_d;
      rs1_e = vec[i].rs1_e; rs2_e = vec[i].rs2_e;
      rd_e = vec[i].rd_e; rd_m = vec[i].rd_m; rd_w = vec[i].rd_w;
      reg_write_m = vec[i].rwm; reg_write_w = vec[i].rww;
      result_src_e0 = vec[i].ld; pc_src_e = vec[i].pc;
      dmem_wait = vec[i].dw;
      #3;
      chk($sformatf("v%0d_fae", i), fae, vec[i].fae);
      chk($sformatf("v%0d_fbe", i), fbe, vec[i].fbe);
      chk($sformatf("v%0d_ctl", i), ctl_now(), vec[i].ctl);
    end

    // MDU op, start held for 4 cycles.
    do_reset();
    e_se = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    e_bz = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      mdu_start_e = 1'b1;
      #3;
      chk($sformatf("mdu_se%0d", k), se, e_se[k]);
      chk($sformatf("mdu_sm%0d", k), sm, 0);
      chk($sformatf("mdu_busy%0d", k), busy, e_bz[k]);
      chk($sformatf("l1_se%0d", k), l_se, 0);
      chk($sformatf("l1_busy%0d", k), l_busy, 0);
      tick();
    end
    mdu_start_e = 1'b0;
    #3;
    chk("mdu_cnt", cnt, 3);
    chk("mdu_idle", busy, 0);

    // Memory wait for 2 cycles while BUSY with one stall left.
    do_reset();
    e_se = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    e_sm = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    e_bz = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      mdu_start_e = (k == 0);
      dmem_wait = (k == 2 || k == 3);
      pc_src_e = (k == 2 || k == 3);
      #3;
      chk($sformatf("dw_se%0d", k), se, e_se[k]);
      chk($sformatf("dw_sm%0d", k), sm, e_sm[k]);
      chk($sformatf("dw_fd%0d", k), fd, 0);
      chk($sformatf("dw_busy%0d", k), busy, e_bz[k]);
      tick();
    end
    clr();
    #3;
    chk("dw_cnt", cnt, 5);
    chk("dw_idle", busy, 0);

    // Reset in the middle of an op.
    do_reset();
    mdu_start_e = 1'b1;
    tick();
    mdu_start_e = 1'b0;
    tick();
    rst = 1'b1;
    #3;
    chk("rmid_busy_pre", busy, 1);
    chk("rmid_flush", {fd, fe}, 2'b11);
    chk("rmid_se", se, 0);
    tick();
    rst = 1'b0;
    #3;
    chk("rmid_busy", busy, 0);
    chk("rmid_cnt", cnt, 0);
    chk("rmid_se_post", se, 0);

    // Counter saturation on a 4-bit instance.
    do_reset();
    result_src_e0 = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        #3;
        chk("sat_mid16", cnt, 10);
        chk("sat_mid4", s_cnt, 10);
      end
      tick();
    end
    #3;
    chk("sat_cnt16", cnt, 20);
    chk("sat_cnt4", s_cnt, 15);
    for (int i = 0; i < 3; i++) tick();
    #3;
    chk("sat_hold4", s_cnt, 15);
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, giving the register-address width.
REQ-002 The block SHALL have parameter MDU_LAT, default 4, giving the number of cycles a multi-cycle (MUL/DIV) op occupies E; legal range 1..64.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the stall performance-counter width.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset: clk  in  1  clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 The register-address ports SHALL be: rs1_d, rs2_d  in  REG_AW  D-stage sources; rs1_e, rs2_e, rd_e  in  REG_AW  E-stage sources/dest; rd_m, rd_w  in  REG_AW  M/W dests.
REQ-007 The control inputs SHALL be: reg_write_m, reg_write_w  in  1  M/W write enables; result_src_e0  in  1  load in E; pc_src_e  in  1  taken branch/jump in E; mdu_start_e  in  1  multi-cycle op in E; dmem_wait  in  1  data memory not ready (M).
REQ-008 The stall and flush outputs SHALL be: stall_f, stall_d, stall_e, stall_m  out  1  hold stage registers; flush_d, flush_e  out  1  bubble D/E registers.
REQ-009 The status outputs SHALL be: forward_ae, forward_be  out  2  operand source select; mdu_busy  out  1  FSM in BUSY; stall_cnt  out  CNT_W  stall-cycle counter.

Function
REQ-010 forward_ae SHALL be 10 if rs1_e==rd_m, reg_write_m=1 and rs1_e!=0; else 01 if rs1_e==rd_w, reg_write_w=1 and rs1_e!=0; else 00. forward_be SHALL apply the same rule using rs2_e. Both SHALL be combinational and SHALL have zero latency.
REQ-011 lw_stall SHALL be result_src_e0 & rd_e!=0 & (rs1_d==rd_e | rs2_d==rd_e).
REQ-012 The MDU FSM SHALL have states IDLE and BUSY and a down-counter mdu_cnt of width ceil(log2(MDU_LAT)) with a minimum of 1.
REQ-013 In IDLE, if mdu_start_e=1, MDU_LAT>1 and dmem_wait=0, then mdu_stall SHALL be 1, the next state SHALL be BUSY, and mdu_cnt SHALL be loaded with MDU_LAT-2.
REQ-014 In BUSY, if mdu_cnt!=0, then mdu_stall SHALL be 1 and mdu_cnt SHALL decrement. If mdu_cnt==0, then mdu_stall SHALL be 0 and the next state SHALL be IDLE (completion cycle). mdu_start_e SHALL be ignored while in BUSY.
REQ-015 The total mdu_stall assertion per op SHALL be exactly MDU_LAT-1 cycles; with MDU_LAT=1 the FSM SHALL never leave IDLE.
REQ-016 While dmem_wait=1, the FSM state and mdu_cnt SHALL freeze.
REQ-017 If dmem_wait=1, then stall_f, stall_d, stall_e and stall_m SHALL all be 1, and flush_d and flush_e SHALL be 0. This SHALL have highest priority and SHALL suppress pc_src_e and lw_stall effects.
REQ-018 Otherwise, if mdu_stall=1, then stall_f, stall_d and stall_e SHALL be 1, stall_m SHALL be 0, flush_e SHALL be 0, and flush_d SHALL be 0.
REQ-019 Otherwise, stall_f and stall_d SHALL equal lw_stall, stall_e and stall_m SHALL be 0, flush_d SHALL equal pc_src_e, and flush_e SHALL equal lw_stall | pc_src_e.
REQ-020 mdu_busy SHALL be 1 exactly when the state is BUSY.
REQ-021 stall_cnt SHALL increment by 1 on each clock edge where stall_f=1 and SHALL saturate at all-ones without wrapping.

Reset
REQ-022 While rst=1, stall_* SHALL be 0, flush_d and flush_e SHALL be 1, and forward_ae and forward_be SHALL be 00.
REQ-023 On a clock edge with rst=1, the state SHALL go to IDLE, mdu_cnt SHALL go to 0, and stall_cnt SHALL go to 0.
REQ-024 Reset asserted during BUSY SHALL abort the op; the first cycle after reset SHALL show IDLE with no stalls.

Structure
REQ-025 Package hazard_pkg SHALL hold the state enum (IDLE, BUSY) and the forward codes FWD_RF=00, FWD_WB=01, FWD_MEM=10.
REQ-026 The FSM and mdu_cnt SHALL be placed in sub-module mdu_stall_ctrl (ports: clk, rst, start, freeze, stall, busy). Forwarding, priority logic and stall_cnt SHALL remain in the top module.

Verification
REQ-027 Forwarding: rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> forward_ae=10; set rs1_e=0 -> forward_ae=00.
REQ-028 Load-use: result_src_e0=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for one cycle; with rd_e=0 -> no stall.
REQ-029 MDU with MDU_LAT=4: pulse sequence with mdu_start_e held 4 cycles -> stall_e=1 for exactly 3 cycles, mdu_busy=1 for 3 cycles; stall_cnt increases by 3.
REQ-030 dmem_wait=1 for 2 cycles during BUSY (mdu_cnt=1) -> all four stalls=1, counter frozen, total stall window extends by 2 cycles; pc_src_e=1 in that window -> flush_d=0.
REQ-031 rst=1 asserted mid-BUSY -> next cycle mdu_busy=0 and stall_cnt=0; while rst=1, flush_d=flush_e=1.
REQ-032 Saturation: CNT_W=4 with 20 consecutive stall cycles -> stall_cnt=15 that holds.
